// File: rtl/game_input_conditioner.sv
// Button conditioner for the game-logic stage.
// Each of left/right/throw is synchronised, debounced on sample_tick, and turned into a
// sticky event flag. Left/right can auto-repeat while held. consume clears the flags, and
// overrun records any event that landed on a flag that was already set.
module game_input_conditioner #(
  parameter int unsigned DEBOUNCE_CNT  = 20,
  parameter int unsigned REPEAT_DELAY  = 400,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter logic [2:0]  REPEAT_MASK   = 3'b011,
  parameter int unsigned CNT_W         = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic [2:0] btn_raw,
  input  logic       consume,
  output logic [2:0] evt,
  output logic [2:0] held,
  output logic [2:0] overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StRepeat,
    StReleaseWait
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] DebLim = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] DlyLim = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PerLim = CNT_W'(REPEAT_PERIOD);

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       s;
  state_e           state_q [3];
  state_e           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       held_q, held_d;
  logic [2:0]       evt_q, evt_d;
  logic [2:0]       overrun_q, overrun_d;
  logic [2:0]       raise, rep_raise, evt_raise;

  assign s = sync2_q;

  // Per-channel debounce / auto-repeat next-state; only a sample_tick moves anything.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      held_d[i]    = held_q[i];
      raise[i]     = 1'b0;
      rep_raise[i] = 1'b0;
      if (sample_tick) begin
        case (state_q[i])
          StIdle: begin
            if (s[i]) begin
              if (DEBOUNCE_CNT == 1) begin
                state_d[i] = StHeld;
                held_d[i]  = 1'b1;
                raise[i]   = 1'b1;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = StPressWait;
                cnt_d[i]   = CntOne;
              end
            end
          end
          StPressWait: begin
            if (!s[i]) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CntOne == DebLim) begin
              state_d[i] = StHeld;
              held_d[i]  = 1'b1;
              raise[i]   = 1'b1;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end
          StHeld, StRepeat: begin
            if (!s[i]) begin
              // A single-tick debounce releases at once; release-wait could never match.
              if (DEBOUNCE_CNT == 1) begin
                state_d[i] = StIdle;
                held_d[i]  = 1'b0;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = StReleaseWait;
                cnt_d[i]   = CntOne;
              end
            end else if (state_q[i] == StRepeat) begin
              if (cnt_q[i] + CntOne == PerLim) begin
                raise[i]     = 1'b1;
                rep_raise[i] = 1'b1;
                cnt_d[i]     = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end else if (REPEAT_MASK[i]) begin
              if (cnt_q[i] + CntOne == DlyLim) begin
                state_d[i]   = StRepeat;
                raise[i]     = 1'b1;
                rep_raise[i] = 1'b1;
                cnt_d[i]     = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end else begin
              cnt_d[i] = '0;
            end
          end
          StReleaseWait: begin
            if (s[i]) begin
              // Bounce during release: back to held, repeat delay restarts, no new event.
              state_d[i] = StHeld;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CntOne == DebLim) begin
              state_d[i] = StIdle;
              held_d[i]  = 1'b0;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Left/right conflict filtering and sticky flag update (raise > consume > hold).
  always_comb begin
    evt_raise = raise;
    if (held_q[0] && held_q[1]) begin
      evt_raise[1:0] = raise[1:0] & ~rep_raise[1:0];
    end
    if (evt_raise[0] && evt_raise[1]) begin
      evt_raise[1:0] = 2'b00;
    end
    evt_d     = evt_raise | (evt_q & ~{3{consume}});
    overrun_d = overrun_q | (evt_raise & evt_q & ~{3{consume}});
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      held_q    <= '0;
      evt_q     <= '0;
      overrun_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      held_q    <= held_d;
      evt_q     <= evt_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign evt     = evt_q;
  assign held    = held_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Bench for game_input_conditioner: directed scenarios plus random button activity,
// checked every cycle against a tick-level reference model through an expectation queue.
module tb_game_input_conditioner;

  localparam int Deb = 4;
  localparam int Dly = 10;
  localparam int Per = 3;
  localparam logic [2:0] Mask = 3'b011;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       consume = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] evt, held, overrun;

  always #5 CLK = ~CLK;

  game_input_conditioner #(
    .DEBOUNCE_CNT (Deb),
    .REPEAT_DELAY (Dly),
    .REPEAT_PERIOD(Per),
    .REPEAT_MASK  (Mask),
    .CNT_W        (10)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .sample_tick(sample_tick),
    .btn_raw    (btn_raw),
    .consume    (consume),
    .evt        (evt),
    .held       (held),
    .overrun    (overrun)
  );

  // Model: debounced level, ticks of disagreement, ticks held since (re)acceptance.
  typedef struct packed {
    logic [2:0]       sy1;
    logic [2:0]       sy2;
    logic [2:0]       level;
    logic [2:0]       evt;
    logic [2:0]       overrun;
    logic [2:0]       raise;
    logic [2:0][15:0] pend;
    logic [2:0][31:0] age;
  } mst_t;

  mst_t       mst = '0;
  logic [8:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         div = 0;
  logic       auto_cons = 1'b0;
  logic       cons_on_raise1 = 1'b0;
  logic       collided = 1'b0;
  int         evt2_rises = 0;
  logic       evt2_prev = 1'b0;

  function automatic mst_t model_step(mst_t st, logic [2:0] btn, logic tick, logic cons,
                                      logic rst);
    mst_t       n = st;
    logic [2:0] r = 3'b000;
    logic [2:0] rep = 3'b000;
    int         p, a;
    if (rst) begin
      n = '0;
      return n;
    end
    if (tick) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (st.sy2[ch] != st.level[ch]) begin
          p = int'(st.pend[ch]) + 1;
          n.pend[ch] = 16'(p);
          if (p == Deb) begin
            n.level[ch] = st.sy2[ch];
            n.pend[ch]  = '0;
            n.age[ch]   = '0;
            if (st.sy2[ch]) r[ch] = 1'b1;
          end
        end else if (st.level[ch]) begin
          if (st.pend[ch] != 0) begin
            n.pend[ch] = '0;
            n.age[ch]  = '0;
          end else if (Mask[ch]) begin
            a = int'(st.age[ch]) + 1;
            n.age[ch] = 32'(a);
            if (a >= Dly && ((a - Dly) % Per) == 0) begin
              r[ch]   = 1'b1;
              rep[ch] = 1'b1;
            end
          end
        end else begin
          n.pend[ch] = '0;
        end
      end
    end
    if (st.level[0] && st.level[1]) r[1:0] = r[1:0] & ~rep[1:0];
    if (r[0] && r[1]) r[1:0] = 2'b00;
    n.raise = r;
    for (int ch = 0; ch < 3; ch++) begin
      n.overrun[ch] = st.overrun[ch] | (r[ch] & st.evt[ch] & ~cons);
      n.evt[ch]     = r[ch] ? 1'b1 : (cons ? 1'b0 : st.evt[ch]);
    end
    n.sy2 = st.sy1;
    n.sy1 = btn;
    return n;
  endfunction

  // Scoreboard producer: advance the model on every edge and queue the expected outputs.
  initial begin
    forever begin
      @(posedge CLK);
      mst = model_step(mst, btn_raw, sample_tick, consume, reset);
      exp_q.push_back({mst.evt, mst.level, mst.overrun});
    end
  end

  // Scoreboard consumer: compare DUT outputs on the falling edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (evt[2] && !evt2_prev) evt2_rises++;
      evt2_prev = evt[2];
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({evt, held, overrun} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t evt/held/overrun got %b/%b/%b required %b/%b/%b",
                   $time, evt, held, overrun, e[8:6], e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Drive inputs for the next edge; tick every fifth CLK.
  task automatic step(input logic [2:0] btn, input logic cons, input logic rst);
    mst_t tmp;
    logic c;
    @(posedge CLK);
    #1;
    btn_raw     = btn;
    reset       = rst;
    sample_tick = (div == 4);
    div         = (div == 4) ? 0 : div + 1;
    c           = cons | (auto_cons & (mst.evt != 3'b000));
    if (cons_on_raise1) begin
      tmp = model_step(mst, btn, sample_tick, 1'b0, rst);
      if (tmp.raise[1]) begin
        c              = 1'b1;
        cons_on_raise1 = 1'b0;
        collided       = 1'b1;
      end
    end
    consume = c;
  endtask

  task automatic run(input logic [2:0] btn, input int ncyc);
    for (int k = 0; k < ncyc; k++) step(btn, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    int len;
    logic [2:0] b;
    repeat (3) step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);

    // Reset during a held press.
    run(3'b001, 150);
    step(3'b001, 1'b0, 1'b1);
    step(3'b001, 1'b0, 1'b0);
    chk("t1_evt_after_reset", int'(evt), 0);
    chk("t1_held_after_reset", int'(held), 0);
    chk("t1_overrun_after_reset", int'(overrun), 0);
    run(3'b001, 40);
    run(3'b000, 60);

    // Bounce rejection on throw.
    do_reset();
    run(3'b100, 15);
    run(3'b000, 60);
    chk("t2_evt2", int'(evt[2]), 0);
    chk("t2_held2", int'(held[2]), 0);

    // Clean press on throw with consume.
    do_reset();
    evt2_rises = 0;
    auto_cons  = 1'b1;
    run(3'b100, 200);
    chk("t3_held2_while_pressed", int'(held[2]), 1);
    run(3'b000, 60);
    auto_cons = 1'b0;
    chk("t3_evt2_pulses", evt2_rises, 1);
    chk("t3_held2_released", int'(held[2]), 0);
    chk("t3_overrun", int'(overrun), 0);

    // Auto-repeat on left, no consume.
    do_reset();
    run(3'b001, 125);
    chk("t4_evt0", int'(evt[0]), 1);
    chk("t4_held0", int'(held[0]), 1);
    chk("t4_overrun0", int'(overrun[0]), 1);
    run(3'b000, 60);

    // Consume colliding with a right press event.
    do_reset();
    collided       = 1'b0;
    cons_on_raise1 = 1'b1;
    for (int k = 0; k < 200 && !collided; k++) step(3'b010, 1'b0, 1'b0);
    cons_on_raise1 = 1'b0;
    step(3'b010, 1'b0, 1'b0);
    chk("t5_collided", int'(collided), 1);
    chk("t5_evt1_kept", int'(evt[1]), 1);
    step(3'b010, 1'b1, 1'b0);
    step(3'b010, 1'b0, 1'b0);
    chk("t5_evt1_cleared", int'(evt[1]), 0);
    run(3'b000, 60);

    // Simultaneous left and right.
    do_reset();
    run(3'b011, 100);
    chk("t6_held", int'(held), 3);
    chk("t6_evt_lr", int'(evt[1:0]), 0);
    chk("t6_overrun", int'(overrun), 0);
    run(3'b000, 60);

    // Random activity with sporadic consume and reset.
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      b         = 3'($urandom_range(0, 7));
      len       = int'($urandom_range(1, 80));
      auto_cons = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++) begin
        step(b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 1999) == 0));
      end
    end
    auto_cons = 1'b0;

    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
